// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesting engines and the arbiter.
//   req        requester -> arbiter   request vector, bit i = requester i
//   rel        requester -> arbiter   current owner is done (only honoured while gnt_valid)
//   gnt        arbiter -> requester   one-hot grant
//   gnt_idx    arbiter -> requester   binary index of the granted requester
//   gnt_valid  arbiter -> requester   a grant is active
//   timeout    arbiter -> requester   one-cycle pulse: grant revoked by the hold limit
interface rr_grant_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
    logic [N_REQ-1:0] req;
    logic             rel;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    // Requester side
    modport master (
        output req, rel,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    // Arbiter side
    modport slave (
        input  req, rel,
        output gnt, gnt_idx, gnt_valid, timeout
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Registered N-way arbiter with grant hold, round-robin or fixed priority,
// and an optional hold timeout.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_grant_arbiter_if.slave: req/rel in, gnt/gnt_idx/gnt_valid/timeout out (all registered)
module rr_grant_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned IDX_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    parameter int unsigned ROUND_ROBIN = 1,
    parameter int unsigned MAX_HOLD    = 0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    rr_grant_arbiter_if.slave   bus
);

    localparam bit               HAS_TO    = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = HAS_TO ? CNT_W'(MAX_HOLD - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_REQ - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [N_REQ-1:0] gnt_n;
    logic [IDX_W-1:0] gnt_idx_n;
    logic             gnt_valid_n;
    logic             timeout_n;

    logic             hold_hit_c;
    logic             end_evt_c;
    logic [IDX_W-1:0] ptr_upd_c;
    logic [IDX_W-1:0] arb_ptr_c;
    logic [IDX_W-1:0] lo_all_c, lo_ptr_c, sel_idx_c;
    logic             hit_ptr_c, sel_any_c;

    // End-of-grant detection and the pointer that follows the current owner
    always_comb begin
        hold_hit_c = HAS_TO && (cnt == HOLD_LAST);
        end_evt_c  = (state == BUSY) && (bus.rel || hold_hit_c);
        ptr_upd_c  = (bus.gnt_idx == IDX_LAST) ? '0 : bus.gnt_idx + IDX_W'(1);
        // Re-arbitration on an end event already uses the advanced pointer
        arb_ptr_c  = end_evt_c ? ptr_upd_c : ptr;
    end

    // Selection: downward scans leave the lowest matching index behind
    always_comb begin
        lo_all_c  = '0;
        lo_ptr_c  = '0;
        hit_ptr_c = 1'b0;
        sel_any_c = |bus.req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                lo_all_c = IDX_W'(i);
                if (IDX_W'(i) >= arb_ptr_c) begin
                    lo_ptr_c  = IDX_W'(i);
                    hit_ptr_c = 1'b1;
                end
            end
        end
        sel_idx_c = ((ROUND_ROBIN != 0) && hit_ptr_c) ? lo_ptr_c : lo_all_c;
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        cnt_n       = cnt;
        gnt_n       = bus.gnt;
        gnt_idx_n   = bus.gnt_idx;
        gnt_valid_n = bus.gnt_valid;
        timeout_n   = 1'b0;

        case (state)
            IDLE: begin
                if (sel_any_c) begin
                    state_n     = BUSY;
                    gnt_n       = N_REQ'(1) << sel_idx_c;
                    gnt_idx_n   = sel_idx_c;
                    gnt_valid_n = 1'b1;
                    cnt_n       = '0;
                end
            end
            BUSY: begin
                cnt_n = (cnt == '1) ? cnt : cnt + CNT_W'(1);
                if (end_evt_c) begin
                    ptr_n     = ptr_upd_c;
                    // A release in the same cycle outranks the timeout
                    timeout_n = hold_hit_c && !bus.rel;
                    cnt_n     = '0;
                    if (sel_any_c) begin
                        gnt_n       = N_REQ'(1) << sel_idx_c;
                        gnt_idx_n   = sel_idx_c;
                        gnt_valid_n = 1'b1;
                    end else begin
                        state_n     = IDLE;
                        gnt_n       = '0;
                        gnt_valid_n = 1'b0;
                    end
                end
            end
            default: begin
                state_n     = IDLE;
                gnt_n       = '0;
                gnt_valid_n = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            cnt           <= '0;
            bus.gnt       <= '0;
            bus.gnt_idx   <= '0;
            bus.gnt_valid <= 1'b0;
            bus.timeout   <= 1'b0;
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            cnt           <= cnt_n;
            bus.gnt       <= gnt_n;
            bus.gnt_idx   <= gnt_idx_n;
            bus.gnt_valid <= gnt_valid_n;
            bus.timeout   <= timeout_n;
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: a round-robin instance, a fixed-priority
// instance and a round-robin instance with a 3-cycle hold limit share clock and reset.
module tb_rr_grant_arbiter;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    rr_grant_arbiter_if #(.N_REQ(4), .IDX_W(2)) b_rr ();
    rr_grant_arbiter_if #(.N_REQ(4), .IDX_W(2)) b_fx ();
    rr_grant_arbiter_if #(.N_REQ(4), .IDX_W(2)) b_to ();

    rr_grant_arbiter #(.N_REQ(4), .IDX_W(2), .ROUND_ROBIN(1), .MAX_HOLD(0), .CNT_W(16)) u_rr (
        .clk(clk), .rst_n(rst_n), .bus(b_rr)
    );
    rr_grant_arbiter #(.N_REQ(4), .IDX_W(2), .ROUND_ROBIN(0), .MAX_HOLD(0), .CNT_W(16)) u_fx (
        .clk(clk), .rst_n(rst_n), .bus(b_fx)
    );
    rr_grant_arbiter #(.N_REQ(4), .IDX_W(2), .ROUND_ROBIN(1), .MAX_HOLD(3), .CNT_W(16)) u_to (
        .clk(clk), .rst_n(rst_n), .bus(b_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag,
                           input logic [3:0] og, input logic [1:0] oi, input logic ov, input logic ot,
                           input logic [3:0] eg, input logic [1:0] ei, input logic ev, input logic et);
        chk({tag, ".gnt"},       32'(og), 32'(eg));
        chk({tag, ".gnt_idx"},   32'(oi), 32'(ei));
        chk({tag, ".gnt_valid"}, 32'(ov), 32'(ev));
        chk({tag, ".timeout"},   32'(ot), 32'(et));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        b_rr.req = '0; b_rr.rel = 1'b0;
        b_fx.req = '0; b_fx.rel = 1'b0;
        b_to.req = '0; b_to.rel = 1'b0;

        // Reset values
        #3;
        chk_out("rst_rr", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0000, 2'd0, 1'b0, 1'b0);
        chk_out("rst_fx", b_fx.gnt, b_fx.gnt_idx, b_fx.gnt_valid, b_fx.timeout, 4'b0000, 2'd0, 1'b0, 1'b0);
        chk_out("rst_to", b_to.gnt, b_to.gnt_idx, b_to.gnt_valid, b_to.timeout, 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;

        // T1: idle with no requests
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out("t1_idle", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0000, 2'd0, 1'b0, 1'b0);
        end

        // T2: all request, rotation 0,1,2,3,0 back-to-back, grant held while rel=0
        b_rr.req = 4'b1111;
        tick();
        chk_out("t2_first", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0001, 2'd0, 1'b1, 1'b0);
        b_rr.rel = 1'b1;
        tick();
        chk_out("t2_rot1", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0010, 2'd1, 1'b1, 1'b0);
        b_rr.rel = 1'b0;
        tick();
        chk_out("t2_hold1", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0010, 2'd1, 1'b1, 1'b0);
        b_rr.rel = 1'b1;
        tick();
        chk_out("t2_rot2", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0100, 2'd2, 1'b1, 1'b0);
        b_rr.rel = 1'b0;
        tick();
        chk_out("t2_hold2", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0100, 2'd2, 1'b1, 1'b0);
        b_rr.rel = 1'b1;
        tick();
        chk_out("t2_rot3", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b1000, 2'd3, 1'b1, 1'b0);
        b_rr.rel = 1'b0;
        tick();
        chk_out("t2_hold3", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b1000, 2'd3, 1'b1, 1'b0);
        b_rr.rel = 1'b1;
        tick();
        chk_out("t2_rot0", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0001, 2'd0, 1'b1, 1'b0);

        // T3: grant to 2 leaves pointer at 3; 0011 wraps to 0, then 1
        b_rr.req = 4'b0100;
        tick();
        chk_out("t3_to2", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0100, 2'd2, 1'b1, 1'b0);
        b_rr.req = 4'b0011;
        tick();
        chk_out("t3_wrap0", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        chk_out("t3_next1", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0010, 2'd1, 1'b1, 1'b0);
        b_rr.req = 4'b0000;
        tick();
        chk_out("t3_drop", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0000, 2'd1, 1'b0, 1'b0);
        tick();
        chk_out("t3_rel_idle", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0000, 2'd1, 1'b0, 1'b0);
        b_rr.rel = 1'b0;

        // Owner dropping req keeps the grant (pointer 2, only 0 requests -> wraps to 0)
        b_rr.req = 4'b0001;
        tick();
        chk_out("own_grant", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0001, 2'd0, 1'b1, 1'b0);
        b_rr.req = 4'b0000;
        tick();
        chk_out("own_dropreq", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0001, 2'd0, 1'b1, 1'b0);
        b_rr.rel = 1'b1;
        tick();
        chk_out("own_release", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0000, 2'd0, 1'b0, 1'b0);
        b_rr.rel = 1'b0;

        // X on req while busy leaves outputs untouched (pointer 1 -> grant 1)
        b_rr.req = 4'b0010;
        tick();
        chk_out("x_grant", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0010, 2'd1, 1'b1, 1'b0);
        b_rr.req = 4'bxxxx;
        tick();
        chk_out("x_hold_a", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        chk_out("x_hold_b", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0010, 2'd1, 1'b1, 1'b0);
        b_rr.req = 4'b0000;
        b_rr.rel = 1'b1;
        tick();
        chk_out("x_release", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0000, 2'd1, 1'b0, 1'b0);
        b_rr.rel = 1'b0;

        // T4: fixed priority keeps re-granting the lowest index
        b_fx.req = 4'b1010;
        tick();
        chk_out("t4_first", b_fx.gnt, b_fx.gnt_idx, b_fx.gnt_valid, b_fx.timeout, 4'b0010, 2'd1, 1'b1, 1'b0);
        b_fx.rel = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out("t4_regrant", b_fx.gnt, b_fx.gnt_idx, b_fx.gnt_valid, b_fx.timeout, 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        b_fx.req = 4'b1000;
        tick();
        chk_out("t4_idx3", b_fx.gnt, b_fx.gnt_idx, b_fx.gnt_valid, b_fx.timeout, 4'b1000, 2'd3, 1'b1, 1'b0);
        b_fx.req = 4'b0000;
        tick();
        chk_out("t4_drop", b_fx.gnt, b_fx.gnt_idx, b_fx.gnt_valid, b_fx.timeout, 4'b0000, 2'd3, 1'b0, 1'b0);
        b_fx.rel = 1'b0;

        // T5: hold limit 3, no release -> 3 valid cycles then timeout pulse with re-grant
        b_to.req = 4'b0100;
        tick();
        chk_out("t5_c0", b_to.gnt, b_to.gnt_idx, b_to.gnt_valid, b_to.timeout, 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        chk_out("t5_c1", b_to.gnt, b_to.gnt_idx, b_to.gnt_valid, b_to.timeout, 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        chk_out("t5_c2", b_to.gnt, b_to.gnt_idx, b_to.gnt_valid, b_to.timeout, 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        chk_out("t5_pulse", b_to.gnt, b_to.gnt_idx, b_to.gnt_valid, b_to.timeout, 4'b0100, 2'd2, 1'b1, 1'b1);
        tick();
        chk_out("t5_after", b_to.gnt, b_to.gnt_idx, b_to.gnt_valid, b_to.timeout, 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        chk_out("t5v_c2", b_to.gnt, b_to.gnt_idx, b_to.gnt_valid, b_to.timeout, 4'b0100, 2'd2, 1'b1, 1'b0);
        // Release coincides with the timeout cycle: treated as a normal release
        b_to.rel = 1'b1;
        tick();
        chk_out("t5v_relto", b_to.gnt, b_to.gnt_idx, b_to.gnt_valid, b_to.timeout, 4'b0100, 2'd2, 1'b1, 1'b0);
        b_to.req = 4'b0000;
        tick();
        chk_out("t5v_drop", b_to.gnt, b_to.gnt_idx, b_to.gnt_valid, b_to.timeout, 4'b0000, 2'd2, 1'b0, 1'b0);
        b_to.rel = 1'b0;

        // T6: asynchronous reset mid-grant drops the grant at once
        b_rr.req = 4'b0100;
        tick();
        chk_out("t6_grant", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0100, 2'd2, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("t6_async", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0000, 2'd0, 1'b0, 1'b0);
        b_rr.req = 4'b1000;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_out("t6_released", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_out("t6_idx3", b_rr.gnt, b_rr.gnt_idx, b_rr.gnt_valid, b_rr.timeout, 4'b1000, 2'd3, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
